// File: rtl/merger.sv
// Packs MERGE_NUM consecutive narrow beats into one wide word, little-endian by slice.
// An upstream last flag closes a partial word early; fwd_keep marks the populated slices.
module merger #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MERGE_NUM = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             bwd_data_i,
    input  logic                          bwd_last_i,
    input  logic                          bwd_vld_i,
    output logic                          bwd_rdy_o,
    output logic [DATA_W*MERGE_NUM-1:0]   fwd_data_o,
    output logic [MERGE_NUM-1:0]          fwd_keep_o,
    output logic                          fwd_vld_o,
    input  logic                          fwd_rdy_i
);

    localparam int unsigned WordW = DATA_W * MERGE_NUM;
    localparam int unsigned CntW  = (MERGE_NUM > 2) ? $clog2(MERGE_NUM) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MERGE_NUM - 1);

    logic [WordW-1:0]     acc_buf_q, acc_buf_d;
    logic [MERGE_NUM-1:0] acc_keep_q, acc_keep_d;
    logic [CntW-1:0]      acc_cnt_q, acc_cnt_d;
    logic                 acc_pend_q, acc_pend_d;
    logic [WordW-1:0]     out_data_q, out_data_d;
    logic [MERGE_NUM-1:0] out_keep_q, out_keep_d;
    logic                 out_vld_q, out_vld_d;

    logic                 bwd_hsk;
    logic                 fwd_hsk;
    logic                 out_free;
    logic                 close;
    logic [WordW-1:0]     merged_data;
    logic [MERGE_NUM-1:0] merged_keep;

    assign bwd_rdy_o  = ~acc_pend_q;
    assign fwd_vld_o  = out_vld_q;
    assign fwd_data_o = out_data_q;
    assign fwd_keep_o = out_keep_q;

    assign bwd_hsk  = bwd_vld_i & ~acc_pend_q;
    assign fwd_hsk  = out_vld_q & fwd_rdy_i;
    assign out_free = ~out_vld_q | fwd_rdy_i;
    assign close    = bwd_hsk & (bwd_last_i | (acc_cnt_q == CntMax));

    // Accumulator contents with the incoming beat dropped into slice acc_cnt.
    always_comb begin
        merged_data = acc_buf_q;
        merged_keep = acc_keep_q;
        for (int unsigned i = 0; i < MERGE_NUM; i++) begin
            if (CntW'(i) == acc_cnt_q) begin
                merged_data[i*DATA_W +: DATA_W] = bwd_data_i;
                merged_keep[i]                  = 1'b1;
            end
        end
    end

    always_comb begin
        acc_buf_d  = acc_buf_q;
        acc_keep_d = acc_keep_q;
        acc_cnt_d  = acc_cnt_q;
        acc_pend_d = acc_pend_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_vld_d  = out_vld_q;

        if (acc_pend_q) begin
            // Upstream is stalled; the finished word waits for the output slot.
            if (fwd_hsk) begin
                out_data_d = acc_buf_q;
                out_keep_d = acc_keep_q;
                out_vld_d  = 1'b1;
                acc_buf_d  = '0;
                acc_keep_d = '0;
                acc_pend_d = 1'b0;
            end
        end else begin
            if (bwd_hsk) begin
                acc_cnt_d = close ? '0 : acc_cnt_q + CntW'(1);
            end
            if (close && out_free) begin
                out_data_d = merged_data;
                out_keep_d = merged_keep;
                out_vld_d  = 1'b1;
                acc_buf_d  = '0;
                acc_keep_d = '0;
            end else if (close) begin
                acc_buf_d  = merged_data;
                acc_keep_d = merged_keep;
                acc_pend_d = 1'b1;
            end else begin
                if (bwd_hsk) begin
                    acc_buf_d  = merged_data;
                    acc_keep_d = merged_keep;
                end
                if (fwd_hsk) begin
                    out_vld_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_buf_q  <= '0;
            acc_keep_q <= '0;
            acc_cnt_q  <= '0;
            acc_pend_q <= 1'b0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            acc_buf_q  <= acc_buf_d;
            acc_keep_q <= acc_keep_d;
            acc_cnt_q  <= acc_cnt_d;
            acc_pend_q <= acc_pend_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_vld_q  <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_merger.sv
// Directed and random-stream checks of the merger packing, backpressure and reset behaviour.
module tb_merger;

    localparam int unsigned DW = 32;
    localparam int unsigned MN = 4;
    localparam int unsigned WW = DW * MN;

    logic          clk;
    logic          rst;
    logic [DW-1:0] bwd_data;
    logic          bwd_last;
    logic          bwd_vld;
    logic          bwd_rdy;
    logic [WW-1:0] fwd_data;
    logic [MN-1:0] fwd_keep;
    logic          fwd_vld;
    logic          fwd_rdy;

    int tests;
    int fails;

    merger #(
        .DATA_W    (DW),
        .MERGE_NUM (MN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bwd_data_i (bwd_data),
        .bwd_last_i (bwd_last),
        .bwd_vld_i  (bwd_vld),
        .bwd_rdy_o  (bwd_rdy),
        .fwd_data_o (fwd_data),
        .fwd_keep_o (fwd_keep),
        .fwd_vld_o  (fwd_vld),
        .fwd_rdy_i  (fwd_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        bwd_data = '0;
        bwd_last = 1'b0;
        bwd_vld  = 1'b0;
        fwd_rdy  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (fwd_vld !== 1'b0 || bwd_rdy !== 1'b1 || fwd_keep !== '0 || fwd_data !== '0) begin
            fails++;
            $display("FAIL reset_in: vld=%b rdy=%b keep=%b data=%h, want 0 1 0000 0",
                     fwd_vld, bwd_rdy, fwd_keep, fwd_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (fwd_vld !== 1'b0 || bwd_rdy !== 1'b1 || fwd_keep !== '0) begin
                fails++;
                $display("FAIL reset_idle[%0d]: vld=%b rdy=%b keep=%b, want 0 1 0000",
                         i, fwd_vld, bwd_rdy, fwd_keep);
            end
        end
    endtask

    task automatic test_full_pack();
        logic [DW-1:0] beats [4];
        beats[0] = 32'h11;
        beats[1] = 32'h22;
        beats[2] = 32'h33;
        beats[3] = 32'h44;
        fwd_rdy  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bwd_vld  = 1'b1;
            bwd_last = 1'b0;
            bwd_data = beats[i];
            tick();
            if (i == 2) begin
                tests++;
                if (fwd_vld !== 1'b0) begin
                    fails++;
                    $display("FAIL full_early: vld=%b, want 0", fwd_vld);
                end
            end
        end
        bwd_vld = 1'b0;
        tests++;
        if (fwd_vld !== 1'b1 || fwd_keep !== 4'b1111 ||
            fwd_data !== 128'h00000044_00000033_00000022_00000011) begin
            fails++;
            $display("FAIL full_word: vld=%b keep=%b data=%h, want 1 1111 %h",
                     fwd_vld, fwd_keep, fwd_data, 128'h00000044_00000033_00000022_00000011);
        end
        tick();
        tests++;
        if (fwd_vld !== 1'b0) begin
            fails++;
            $display("FAIL full_hold: vld=%b, want 0", fwd_vld);
        end
    endtask

    task automatic test_partial();
        fwd_rdy  = 1'b1;
        bwd_vld  = 1'b1;
        bwd_last = 1'b0;
        bwd_data = 32'hAA;
        tick();
        bwd_last = 1'b1;
        bwd_data = 32'hBB;
        tick();
        bwd_vld  = 1'b0;
        bwd_last = 1'b0;
        tests++;
        if (fwd_vld !== 1'b1 || fwd_keep !== 4'b0011 ||
            fwd_data !== 128'h00000000_00000000_000000BB_000000AA) begin
            fails++;
            $display("FAIL partial_word: vld=%b keep=%b data=%h, want 1 0011 %h",
                     fwd_vld, fwd_keep, fwd_data, 128'h000000BB_000000AA);
        end
        bwd_vld  = 1'b1;
        bwd_last = 1'b1;
        bwd_data = 32'hCC;
        tick();
        bwd_vld  = 1'b0;
        bwd_last = 1'b0;
        tests++;
        if (fwd_vld !== 1'b1 || fwd_keep !== 4'b0001 || fwd_data !== 128'hCC) begin
            fails++;
            $display("FAIL partial_next_slice0: vld=%b keep=%b data=%h, want 1 0001 cc",
                     fwd_vld, fwd_keep, fwd_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [WW-1:0] w1;
        logic [WW-1:0] w2;
        w1 = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
        w2 = {32'hB8, 32'hB7, 32'hB6, 32'hB5};
        fwd_rdy  = 1'b0;
        bwd_last = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bwd_vld  = 1'b1;
            bwd_data = 32'hB1 + i;
            tick();
        end
        bwd_vld = 1'b0;
        tests++;
        if (bwd_rdy !== 1'b0 || fwd_vld !== 1'b1 || fwd_data !== w1 || fwd_keep !== 4'b1111) begin
            fails++;
            $display("FAIL bp_stall: rdy=%b vld=%b keep=%b data=%h, want 0 1 1111 %h",
                     bwd_rdy, fwd_vld, fwd_keep, fwd_data, w1);
        end
        tick();
        tests++;
        if (bwd_rdy !== 1'b0 || fwd_vld !== 1'b1 || fwd_data !== w1) begin
            fails++;
            $display("FAIL bp_hold: rdy=%b vld=%b data=%h, want 0 1 %h",
                     bwd_rdy, fwd_vld, fwd_data, w1);
        end
        fwd_rdy = 1'b1;
        tick();
        tests++;
        if (bwd_rdy !== 1'b1 || fwd_vld !== 1'b1 || fwd_data !== w2 || fwd_keep !== 4'b1111) begin
            fails++;
            $display("FAIL bp_drain: rdy=%b vld=%b keep=%b data=%h, want 1 1 1111 %h",
                     bwd_rdy, fwd_vld, fwd_keep, fwd_data, w2);
        end
        tick();
        tests++;
        if (fwd_vld !== 1'b0 || bwd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL bp_empty: vld=%b rdy=%b, want 0 1", fwd_vld, bwd_rdy);
        end
    endtask

    task automatic test_back_to_back();
        fwd_rdy  = 1'b1;
        bwd_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bwd_vld  = 1'b1;
            bwd_data = 32'hD0 + i;
            tick();
            tests++;
            if (fwd_vld !== 1'b1 || fwd_keep !== 4'b0001 || fwd_data !== WW'(32'hD0 + i) ||
                bwd_rdy !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d]: vld=%b rdy=%b keep=%b data=%h, want 1 1 0001 %h",
                         i, fwd_vld, bwd_rdy, fwd_keep, fwd_data, 32'hD0 + i);
            end
        end
        bwd_vld  = 1'b0;
        bwd_last = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        logic [WW-1:0] exp_data [$];
        logic [MN-1:0] exp_keep [$];
        logic [WW-1:0] cur_data;
        logic [MN-1:0] cur_keep;
        logic [WW-1:0] ed;
        logic [MN-1:0] ek;
        int            cur_cnt;
        int            sent;
        int            words;
        int            cycles;
        logic          have;
        cur_data = '0;
        cur_keep = '0;
        cur_cnt  = 0;
        sent     = 0;
        words    = 0;
        cycles   = 0;
        have     = 1'b0;
        bwd_vld  = 1'b0;
        while ((sent < 64 || exp_data.size() != 0) && cycles < 2000) begin
            if (!have && sent < 64 && $urandom_range(0, 3) != 0) begin
                have     = 1'b1;
                bwd_data = $urandom;
                bwd_last = (sent == 63) ? 1'b1 : ($urandom_range(0, 4) == 0);
            end
            bwd_vld = have;
            fwd_rdy = (sent >= 64) ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (fwd_vld && fwd_rdy) begin
                tests++;
                if (exp_data.size() == 0) begin
                    fails++;
                    $display("FAIL stream_extra: keep=%b data=%h, want no word", fwd_keep, fwd_data);
                end else begin
                    ed = exp_data.pop_front();
                    ek = exp_keep.pop_front();
                    if (fwd_data !== ed || fwd_keep !== ek) begin
                        fails++;
                        $display("FAIL stream_word[%0d]: keep=%b data=%h, want %b %h",
                                 words, fwd_keep, fwd_data, ek, ed);
                    end
                end
                words++;
            end
            if (bwd_vld && bwd_rdy) begin
                cur_data[cur_cnt*DW +: DW] = bwd_data;
                cur_keep[cur_cnt]          = 1'b1;
                cur_cnt++;
                if (bwd_last || cur_cnt == MN) begin
                    exp_data.push_back(cur_data);
                    exp_keep.push_back(cur_keep);
                    cur_data = '0;
                    cur_keep = '0;
                    cur_cnt  = 0;
                end
                sent++;
                have = 1'b0;
            end
            tick();
            cycles++;
        end
        bwd_vld  = 1'b0;
        bwd_last = 1'b0;
        fwd_rdy  = 1'b1;
        tests++;
        if (sent != 64 || exp_data.size() != 0) begin
            fails++;
            $display("FAIL stream_done: sent=%0d pending=%0d, want 64 0", sent, exp_data.size());
        end
        tick();
        tests++;
        if (fwd_vld !== 1'b0 || bwd_rdy !== 1'b1) begin
            fails++;
            $display("FAIL stream_idle: vld=%b rdy=%b, want 0 1", fwd_vld, bwd_rdy);
        end
    endtask

    task automatic test_reset_mid();
        fwd_rdy  = 1'b1;
        bwd_last = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bwd_vld  = 1'b1;
            bwd_data = 32'hE1 + i;
            tick();
        end
        bwd_vld = 1'b0;
        rst     = 1'b1;
        #2;
        tests++;
        if (fwd_vld !== 1'b0 || bwd_rdy !== 1'b1 || fwd_keep !== '0) begin
            fails++;
            $display("FAIL rstmid_async: vld=%b rdy=%b keep=%b, want 0 1 0000",
                     fwd_vld, bwd_rdy, fwd_keep);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bwd_vld  = 1'b1;
            bwd_data = 32'hF1 + i;
            tick();
            if (i < 3) begin
                tests++;
                if (fwd_vld !== 1'b0) begin
                    fails++;
                    $display("FAIL rstmid_early[%0d]: vld=%b, want 0", i, fwd_vld);
                end
            end
        end
        bwd_vld = 1'b0;
        tests++;
        if (fwd_vld !== 1'b1 || fwd_keep !== 4'b1111 ||
            fwd_data !== 128'h000000F4_000000F3_000000F2_000000F1) begin
            fails++;
            $display("FAIL rstmid_word: vld=%b keep=%b data=%h, want 1 1111 %h",
                     fwd_vld, fwd_keep, fwd_data, 128'h000000F4_000000F3_000000F2_000000F1);
        end
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_full_pack();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_streaming();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/merger.md
Name: merger

Overview:
- Downstream neighbour of the narrow-stream splitter.
- Consumes a narrow valid/ready stream of DATA_W-bit beats and packs MERGE_NUM consecutive beats into one wide word.
- Emits the wide word on a registered valid/ready forward interface.
- An upstream last flag closes a partial word early; a per-slice keep mask marks which slices carry data.

Parameters:
DATA_W, 32, width of one narrow beat in bits
MERGE_NUM, 4, narrow beats per wide word; legal range is 2 or more

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-high
bwd_data  input  DATA_W  narrow beat
bwd_last  input  1  beat closes the current wide word; qualified by bwd_vld
bwd_vld  input  1  backward valid
bwd_rdy  output  1  backward ready
fwd_data  output  DATA_W*MERGE_NUM  packed word; slice i is bits [i*DATA_W +: DATA_W]
fwd_keep  output  MERGE_NUM  bit i high means slice i holds a received beat
fwd_vld  output  1  forward valid
fwd_rdy  input  1  forward ready

Behaviour:
- Handshakes: bwd_hsk = bwd_vld & bwd_rdy; fwd_hsk = fwd_vld & fwd_rdy.
- Reset (asynchronous, while rst=1):
  - acc_cnt=0, acc_keep=0, acc_pend=0.
  - out_vld=0, out_data=0, out_keep=0.
  - Outputs therefore read fwd_vld=0, fwd_data=0, fwd_keep=0, bwd_rdy=1.
- Reset asserted mid-word discards the partial word and any pending or held word.
- State:
  - Accumulator: acc_buf, acc_keep, acc_cnt (width clog2(MERGE_NUM)), acc_pend.
  - Output register: out_data, out_keep, out_vld.
- Combinational outputs:
  - bwd_rdy = ~acc_pend.
  - fwd_vld = out_vld; fwd_data = out_data; fwd_keep = out_keep.
  - bwd_rdy must not depend on bwd_vld or bwd_last.
- Packing order is little-endian:
  - The first beat of a word goes to slice 0; beat k goes to slice k.
  - On each bwd_hsk: slice acc_cnt of acc_buf <= bwd_data, and acc_keep[acc_cnt] <= 1.
- Word close: a bwd_hsk closes the word when bwd_last=1 or acc_cnt=MERGE_NUM-1.
  - The closing beat is merged into the word.
  - acc_cnt returns to 0.
- out_free = ~out_vld | fwd_rdy.
- Close with out_free=1:
  - The merged word (acc_buf plus the current beat) loads straight into out_data/out_keep, and out_vld <= 1.
  - acc_buf and acc_keep clear to 0.
  - Latency: 1 cycle from the closing beat's handshake to fwd_vld.
- Close with out_free=0:
  - The merged word stays in the accumulator and acc_pend <= 1, so bwd_rdy drops.
- Pending drain:
  - While acc_pend=1, the edge with fwd_hsk moves acc_buf/acc_keep into out, keeps out_vld=1, clears the accumulator, and sets acc_pend <= 0.
- Output register otherwise:
  - fwd_hsk with no word to load sets out_vld <= 0.
  - Without fwd_hsk, out_data and out_keep hold stable.
- Unused slices of a partial word read 0 and have keep=0.
- bwd_last on the MERGE_NUM-th beat is equivalent to a full close; fwd_keep is all ones.
- A full word is never emitted with keep=0. An idle bwd_last cannot occur because bwd_last is only sampled on bwd_hsk.
- Throughput:
  - Sustained 1 narrow beat per cycle when fwd_rdy=1.
  - No bubble between consecutive wide words.
  - Back-to-back single-beat words (bwd_last every beat) also run at 1 beat per cycle when fwd_rdy=1.
- Simultaneous events: a closing bwd_hsk and fwd_hsk in the same cycle loads the new word and keeps out_vld=1.
- No data is lost or duplicated under any vld/rdy pattern.

Test Plan:
- Reset then idle, DATA_W=32, MERGE_NUM=4: fwd_vld=0, bwd_rdy=1, fwd_keep=0 at all times.
- Full pack: send beats 0x11,0x22,0x33,0x44 back-to-back with fwd_rdy=1:
  - One cycle after the 4th handshake, fwd_data=0x00000044_00000033_00000022_00000011 and fwd_keep=4'b1111, held for one cycle.
- Partial pack: send 0xAA, then 0xBB with bwd_last=1:
  - fwd_data=0x..._000000BB_000000AA with upper slices 0, fwd_keep=4'b0011.
  - The next beat lands in slice 0.
- Backpressure: fwd_rdy=0, stream 8 beats:
  - Word 1 sits in the output register; word 2 completes and acc_pend=1, so bwd_rdy=0.
  - Raise fwd_rdy: word 1 and word 2 are transferred on consecutive cycles, then bwd_rdy returns to 1.
- Streaming: 64 random beats with random last and random fwd_rdy:
  - The scoreboard reassembles words via fwd_keep and matches the input order exactly, with no loss or duplication.
- Reset mid-word:
  - After 2 beats, pulse rst.
  - fwd_vld=0; the following 4 beats produce one word containing only the post-reset data.
